ram_access_arbiter: RTL and testbench

//   Shares one random_accsess_memory instance between two requesters, A and B.

---
 rtl/ram_access_arbiter.sv | 112 +++++++++++
 tb/tb_ram_access_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port-pair RAM between requesters A and B.
// Commands are registered toward the RAM; read/error responses return two edges after accept.
module ram_access_arbiter #(
  parameter int MEM_SIZE = 6,
  parameter int DATA_W = 10,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_datain,
  output logic [AW-1:0]     ram_addr_w,
  output logic              ram_read,
  output logic [AW-1:0]     ram_addr_r,
  input  logic [DATA_W-1:0] ram_dataout
);

  // Handshake: a command transfers on the rising clock edge where x_valid & x_ready;
  // the requester keeps valid/we/addr/wdata stable until then. Responses have no backpressure.

  logic              last_grant;  // 0 = A was granted last, 1 = B
  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  logic              s1_rd_a;
  logic              s1_rd_b;
  logic              s1_err_a;
  logic              s1_err_b;

  always_comb begin
    grant_a   = reset_n & ~hold & a_valid & (~b_valid | last_grant);
    grant_b   = reset_n & ~hold & b_valid & (~a_valid | ~last_grant);
    accept    = grant_a | grant_b;
    sel_we    = grant_a ? a_we : b_we;
    sel_addr  = grant_a ? a_addr : b_addr;
    sel_wdata = grant_a ? a_wdata : b_wdata;
    sel_oor   = 32'(sel_addr) >= MEM_SIZE;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      ram_write  <= 1'b0;
      ram_read   <= 1'b0;
      ram_addr_w <= '0;
      ram_addr_r <= '0;
      ram_datain <= '0;
    end else begin
      ram_write <= accept & sel_we & ~sel_oor;
      ram_read  <= accept & ~sel_we & ~sel_oor;
      if (accept) begin
        last_grant <= grant_b;
        ram_addr_w <= sel_addr;
        ram_addr_r <= sel_addr;
        ram_datain <= sel_wdata;
      end
    end
  end

  // Response tags travel alongside the RAM access so they line up with ram_dataout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_rd_a  <= 1'b0;
      s1_rd_b  <= 1'b0;
      s1_err_a <= 1'b0;
      s1_err_b <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      s1_rd_a  <= grant_a & ~sel_we;
      s1_rd_b  <= grant_b & ~sel_we;
      s1_err_a <= grant_a & sel_oor;
      s1_err_b <= grant_b & sel_oor;
      a_rvalid <= s1_rd_a;
      b_rvalid <= s1_rd_b;
      a_err    <= s1_err_a;
      b_err    <= s1_err_b;
    end
  end

  // Out-of-range reads never touched the RAM, so their data is forced to zero.
  assign a_rdata = (a_rvalid & ~a_err) ? ram_dataout : '0;
  assign b_rdata = (b_rvalid & ~b_err) ? ram_dataout : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: a RAM model, randomized requesters, and a
// queue-based scoreboard fed by an abstract round-robin/memory reference model.
module tb_ram_access_arbiter;
  localparam int MEM_SIZE = 6;
  localparam int DATA_W = 10;
  localparam int AW = 3;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic hold = 1'b0;
  logic a_valid = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic ram_write, ram_read;
  logic [DATA_W-1:0] ram_datain;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic [DATA_W-1:0] ram_dataout = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // scoreboard: {cycle[31:16], owner_b, err, rvalid, 3'b0, rdata}
  logic [W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem[8] = '{default: '0};
  logic last_b = 1'b1;
  logic a_acc = 1'b0, b_acc = 1'b0;
  logic pend_w = 1'b0, pend_r = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DATA_W-1:0] pend_din = '0;

  logic [DATA_W-1:0] ram_mem[8] = '{default: '0};

  ram_access_arbiter #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .ram_write(ram_write), .ram_datain(ram_datain), .ram_addr_w(ram_addr_w),
    .ram_read(ram_read), .ram_addr_r(ram_addr_r), .ram_dataout(ram_dataout)
  );

  // clock / reset-independent infrastructure
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (ram_write) ram_mem[ram_addr_w] <= ram_datain;
    if (ram_read) ram_dataout <= ram_mem[ram_addr_r];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor + reference model, sampled on the falling edge
  always @(negedge clock) begin
    logic resp_a, resp_b, exp_a, exp_b, own, we, err;
    logic [AW-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [W-1:0] e;
    if (!reset_n) begin
      exp_q.delete();
      pend_w = 1'b0;
      pend_r = 1'b0;
      last_b = 1'b1;
      a_acc = 1'b0;
      b_acc = 1'b0;
    end else begin
      check("ram_write", 32'(ram_write), 32'(pend_w));
      check("ram_read", 32'(ram_read), 32'(pend_r));
      if (pend_w || pend_r) begin
        check("ram_addr_w", 32'(ram_addr_w), 32'(pend_addr));
        check("ram_addr_r", 32'(ram_addr_r), 32'(pend_addr));
      end
      if (pend_w) check("ram_datain", 32'(ram_datain), 32'(pend_din));

      resp_a = a_rvalid | a_err;
      resp_b = b_rvalid | b_err;
      if (!a_rvalid) check("a_rdata_idle", 32'(a_rdata), 32'h0);
      if (!b_rvalid) check("b_rdata_idle", 32'(b_rdata), 32'h0);
      if (resp_a && resp_b) check("single_resp", 32'(resp_b), 32'h0);
      if (resp_a || resp_b) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {30'h0, resp_b, resp_a}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", 32'(cyc), 32'(e[31:16]));
          check("resp_owner", 32'(resp_b), 32'(e[15]));
          check("resp_err", 32'(resp_b ? b_err : a_err), 32'(e[14]));
          check("resp_rvalid", 32'(resp_b ? b_rvalid : a_rvalid), 32'(e[13]));
          check("resp_rdata", 32'(resp_b ? b_rdata : a_rdata), 32'(e[DATA_W-1:0]));
        end
      end else if (exp_q.size() > 0 && exp_q[0][31:16] <= 16'(cyc)) begin
        e = exp_q.pop_front();
        check("missing_resp", 32'h0, 32'(e[31:16]));
      end

      // round robin: when both ask, the one that did not win last time wins
      exp_a = !hold && a_valid && (!b_valid || last_b);
      exp_b = !hold && b_valid && !exp_a;
      check("a_ready", 32'(a_ready), 32'(exp_a));
      check("b_ready", 32'(b_ready), 32'(exp_b));
      a_acc = exp_a;
      b_acc = exp_b;
      pend_w = 1'b0;
      pend_r = 1'b0;
      if (exp_a || exp_b) begin
        own = exp_b;
        we = own ? b_we : a_we;
        addr = own ? b_addr : a_addr;
        wd = own ? b_wdata : a_wdata;
        last_b = own;
        err = 32'(addr) >= MEM_SIZE;
        if (err) begin
          exp_q.push_back({16'(cyc + 2), own, 1'b1, !we, 3'b0, 10'h0});
        end else begin
          pend_w = we;
          pend_r = !we;
          pend_addr = addr;
          pend_din = wd;
          if (we) ref_mem[addr] = wd;
          else exp_q.push_back({16'(cyc + 2), own, 1'b0, 1'b1, 3'b0, ref_mem[addr]});
        end
      end
    end
  end

  // driver tasks
  task automatic cmd(input logic own, input logic we, input logic [AW-1:0] addr,
                     input logic [DATA_W-1:0] d);
    logic done;
    done = 1'b0;
    if (own) begin b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = d; end
    else begin a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = d; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clock);
      #1;
      done = own ? b_acc : a_acc;
    end
    if (!done) check("cmd_timeout", 32'h0, 32'h1);
    if (own) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  task automatic run_random(input int n, input int pv, input int ph);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (a_acc || !a_valid) begin
        a_valid = ($urandom_range(99) < pv);
        a_we = 1'($urandom_range(1));
        a_addr = 3'($urandom_range(7));
        a_wdata = 10'($urandom);
      end
      if (b_acc || !b_valid) begin
        b_valid = ($urandom_range(99) < pv);
        b_we = 1'($urandom_range(1));
        b_addr = 3'($urandom_range(7));
        b_wdata = 10'($urandom);
      end
      hold = ($urandom_range(99) < ph);
    end
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    hold = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, {30'h0, a_ready, b_ready}, 32'h0);
    check({tag, "_resp"}, {28'h0, a_rvalid, a_err, b_rvalid, b_err}, 32'h0);
    check({tag, "_rdata"}, {12'h0, a_rdata, b_rdata}, 32'h0);
    check({tag, "_strobe"}, {30'h0, ram_write, ram_read}, 32'h0);
    check({tag, "_ram_bus"}, {16'h0, ram_datain, ram_addr_w, ram_addr_r}, 32'h0);
  endtask

  initial begin
    // reset: both requesters asking, nothing may be granted
    a_valid = 1'b1;
    b_valid = 1'b1;
    #12;
    check_outputs_zero("reset");
    a_valid = 1'b0;
    b_valid = 1'b0;
    #10;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // write then read back on A
    cmd(1'b0, 1'b1, 3'd3, 10'h155);
    cmd(1'b0, 1'b0, 3'd3, 10'h000);
    idle(4);

    // write by A immediately followed by read of same address by B
    cmd(1'b0, 1'b1, 3'd5, 10'h2AA);
    cmd(1'b1, 1'b0, 3'd5, 10'h000);
    idle(4);

    // out-of-range read and write
    cmd(1'b0, 1'b0, 3'd6, 10'h000);
    cmd(1'b1, 1'b1, 3'd7, 10'h3FF);
    idle(4);

    // hold with both valid
    a_valid = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 10'h011;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 3'd1; b_wdata = 10'h022;
    hold = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    idle(3);

    // sustained contention, then general random traffic
    run_random(6, 100, 0);
    run_random(3000, 70, 15);
    idle(8);

    // reset while a read is in flight
    cmd(1'b0, 1'b0, 3'd2, 10'h000);
    #2;
    reset_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(posedge clock);
    #2;
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset_n = 1'b1;
    idle(8);

    // short random burst after recovery, then drain
    run_random(300, 70, 10);
    idle(8);
    check("drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
